// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative multiply/divide unit with architectural HI/LO.
//
// Executes MULT/MULTU/DIV/DIVU over 32 shift-add / restoring-divide
// iterations (33 busy cycles in total), plus MTHI/MTLO register writes.
// Signed operands are reduced to magnitudes on launch; the result signs
// are applied when the result is written.
//
// Optional feature: define MULDIV_FAST_MUL_EN to route MULT/MULTU through a
// single-cycle hardware multiplier (busy for 1 cycle). Division is unaffected.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    launch operation (sampled only in IDLE)
//   op       00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rs_data  multiplicand / dividend
//   rt_data  multiplier / divisor
//   hi_we    MTHI write strobe (aborts an in-flight operation)
//   lo_we    MTLO write strobe (aborts an in-flight operation)
//   wdata    MTHI/MTLO data
//   flush    abort in-flight operation, HI/LO untouched
//   hi, lo   architectural HI/LO registers
//   busy     operation in flight (CALC or FIN)
//   done     one-cycle pulse after HI/LO take a result
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             flush,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int unsigned W  = WIDTH;
  localparam int unsigned CW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            is_div_q;
  logic [W-1:0]    a_q;       // multiplicand magnitude (mul) / divisor magnitude (div)
  logic [2*W-1:0]  acc_q;     // {partial product, remaining multiplier bits}
  logic [W-1:0]    rem_q;     // divide partial remainder
  logic [W-1:0]    quo_q;     // dividend bits shifting out, quotient bits shifting in
  logic            pneg_q;    // product / quotient sign
  logic            rneg_q;    // remainder sign
  logic            dz_q;      // divide by zero
  logic [W-1:0]    rs_q;      // raw dividend, returned in HI on divide by zero
  logic [W-1:0]    hi_q;
  logic [W-1:0]    lo_q;
  logic            done_q;
`ifdef MULDIV_FAST_MUL_EN
  logic            uns_q;
  logic [W-1:0]    rt_q;
`endif

  // Launch-time operand conditioning.
  logic            sgn_op;
  logic            rs_neg;
  logic            rt_neg;
  logic [W-1:0]    rs_mag;
  logic [W-1:0]    rt_mag;

  assign sgn_op = ~op[0];
  assign rs_neg = sgn_op & rs_data[W-1];
  assign rt_neg = sgn_op & rt_data[W-1];
  assign rs_mag = rs_neg ? -rs_data : rs_data;
  assign rt_mag = rt_neg ? -rt_data : rt_data;

  // One shift-add step: add the multiplicand into the upper half when the
  // current multiplier LSB is set, then shift the whole accumulator right.
  logic [W:0]      mul_sum;
  logic [2*W-1:0]  mul_next;

  assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, a_q} : {(W+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[W-1:1]};

  // One restoring-divide step on a 33-bit partial remainder. Because the
  // remainder is always below the divisor, bit W of the trial difference is
  // a reliable "went negative" flag.
  logic [W:0]      div_shift;
  logic [W:0]      div_trial;
  logic            div_ok;

  assign div_shift = {rem_q, quo_q[W-1]};
  assign div_trial = div_shift - {1'b0, a_q};
  assign div_ok    = ~div_trial[W];

  // Sign-corrected result written in FIN.
  logic [W-1:0]    res_hi;
  logic [W-1:0]    res_lo;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*W-1:0]  fast_a;
  logic [2*W-1:0]  fast_b;
  logic [2*W-1:0]  fast_prod;

  // The low 2W bits of a 2W x 2W product of extended operands equal the
  // signed or unsigned W x W product, depending on the extension.
  assign fast_a    = uns_q ? {{W{1'b0}}, rs_q} : {{W{rs_q[W-1]}}, rs_q};
  assign fast_b    = uns_q ? {{W{1'b0}}, rt_q} : {{W{rt_q[W-1]}}, rt_q};
  assign fast_prod = fast_a * fast_b;
`endif

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    if (is_div_q) begin
      if (dz_q) begin
        res_hi = rs_q;
        res_lo = '1;
      end else begin
        res_lo = pneg_q ? -quo_q : quo_q;
        res_hi = rneg_q ? -rem_q : rem_q;
      end
    end else begin
`ifdef MULDIV_FAST_MUL_EN
      {res_hi, res_lo} = fast_prod;
`else
      {res_hi, res_lo} = pneg_q ? -acc_q : acc_q;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      a_q      <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      pneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      rs_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
`ifdef MULDIV_FAST_MUL_EN
      uns_q    <= 1'b0;
      rt_q     <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      if (flush) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else if (hi_we || lo_we) begin
        if (hi_we) hi_q <= wdata;
        if (lo_we) lo_q <= wdata;
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              is_div_q <= op[1];
              a_q      <= op[1] ? rt_mag : rs_mag;
              acc_q    <= {{W{1'b0}}, rt_mag};
              rem_q    <= '0;
              quo_q    <= rs_mag;
              pneg_q   <= rs_neg ^ rt_neg;
              rneg_q   <= rs_neg;
              dz_q     <= (rt_data == '0);
              rs_q     <= rs_data;
              cnt_q    <= '0;
`ifdef MULDIV_FAST_MUL_EN
              uns_q    <= op[0];
              rt_q     <= rt_data;
              state_q  <= op[1] ? CALC : FIN;
`else
              state_q  <= CALC;
`endif
            end
          end
          CALC: begin
            if (is_div_q) begin
              rem_q <= div_ok ? div_trial[W-1:0] : div_shift[W-1:0];
              quo_q <= {quo_q[W-2:0], div_ok};
            end else begin
              acc_q <= mul_next;
            end
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == '1) state_q <= FIN;
          end
          FIN: begin
            hi_q    <= res_hi;
            lo_q    <= res_lo;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        flush = 1'b0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .flush(flush),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference arithmetic: plain 64-bit math with the architectural rules.
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, sq, sr;
    logic [63:0] ua, ub, uq, ur;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      2'd0: ref_result = sa * sb;
      2'd1: ref_result = ua * ub;
      default: begin
        if (b == 32'd0) ref_result = {a, 32'hFFFF_FFFF};
        else if (o == 2'd2) begin
          sq = sa / sb;
          sr = sa % sb;
          ref_result = {sr[31:0], sq[31:0]};
        end else begin
          uq = ua / ub;
          ur = ua % ub;
          ref_result = {ur[31:0], uq[31:0]};
        end
      end
    endcase
  endfunction

  // Transaction-level model: cycles remaining until the result lands.
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  int          m_left = 0;
  logic        m_done = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi <= '0; m_lo <= '0; m_left <= 0; m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (flush) m_left <= 0;
      else if (hi_we || lo_we) begin
        if (hi_we) m_hi <= wdata;
        if (lo_we) m_lo <= wdata;
        m_left <= 0;
      end else if (m_left != 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_hi <= p_hi; m_lo <= p_lo; m_done <= 1'b1;
        end
      end else if (start) begin
        {p_hi, p_lo} <= ref_result(op, rs_data, rt_data);
        m_left <= op[1] ? DIV_LAT : MUL_LAT;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_hi", hi, m_hi);
      chk("cyc_lo", lo, m_lo);
      chk("cyc_busy", {31'b0, busy}, {31'b0, m_left != 0});
      chk("cyc_done", {31'b0, done}, {31'b0, m_done});
    end
  end

  // Launch one operation and wait for done; checks latency and literal result.
  task automatic do_op(input string name, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                       input int lat);
    int n;
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_lat"}, n, lat + 1);
    chk({name, "_hi"}, hi, ehi);
    chk({name, "_lo"}, lo, elo);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    do_op("mult",  2'd0, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, MUL_LAT);
    do_op("multu", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT);
    do_op("multm", 2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, MUL_LAT);
    do_op("div",   2'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT);
    do_op("div2",  2'd2, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, DIV_LAT);
    do_op("divu0", 2'd3, 32'd7,         32'd0,         32'h0000_0007, 32'hFFFF_FFFF, DIV_LAT);
    do_op("div0",  2'd2, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, DIV_LAT);
    do_op("divov", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DIV_LAT);
    do_op("divu",  2'd3, 32'd100,       32'd7,         32'd2,         32'd14,        DIV_LAT);

    // MTHI / MTLO
    @(negedge clk); hi_we = 1'b1; wdata = 32'h1234_5678;
    @(negedge clk); hi_we = 1'b0;
    chk("mthi", hi, 32'h1234_5678);
    lo_we = 1'b1; wdata = 32'h9ABC_DEF0;
    @(negedge clk); lo_we = 1'b0;
    chk("mtlo", lo, 32'h9ABC_DEF0);

    // DIVU 100/7, ignored second start at E5, flush at E10.
    start = 1'b1; op = 2'd3; rs_data = 32'd100; rt_data = 32'd7;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start = (i == 5);
      if (i == 5) begin op = 2'd0; rs_data = 32'd5; rt_data = 32'd5; end
      flush = (i == 10);
    end
    @(negedge clk); flush = 1'b0;
    chk("flush_busy", {31'b0, busy}, 32'h0);
    chk("flush_done", {31'b0, done}, 32'h0);
    chk("flush_hi", hi, 32'h1234_5678);
    chk("flush_lo", lo, 32'h9ABC_DEF0);
    repeat (3) @(negedge clk);

    // Restart, then asynchronous reset just after E20.
    start = 1'b1; op = 2'd3; rs_data = 32'd100; rt_data = 32'd7;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_rst_busy", {31'b0, busy}, 32'h1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_hi", hi, 32'h0);
    chk("arst_lo", lo, 32'h0);
    chk("arst_busy", {31'b0, busy}, 32'h0);
    chk("arst_done", {31'b0, done}, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    do_op("divu_r", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14, DIV_LAT);

    // start together with MTHI: the write wins, no operation launches.
    @(negedge clk);
    start = 1'b1; op = 2'd0; rs_data = 32'd3; rt_data = 32'd3;
    hi_we = 1'b1; wdata = 32'hAAAA_5555;
    @(negedge clk); start = 1'b0; hi_we = 1'b0;
    chk("sw_hi", hi, 32'hAAAA_5555);
    chk("sw_busy", {31'b0, busy}, 32'h0);

    // MTLO mid-operation aborts it; HI untouched.
    start = 1'b1; op = 2'd3; rs_data = 32'd50; rt_data = 32'd3;
    repeat (5) begin @(negedge clk); start = 1'b0; end
    lo_we = 1'b1; wdata = 32'h0000_0055;
    @(negedge clk); lo_we = 1'b0;
    chk("ab_lo", lo, 32'h0000_0055);
    chk("ab_hi", hi, 32'hAAAA_5555);
    chk("ab_busy", {31'b0, busy}, 32'h0);

    // Simultaneous MTHI + MTLO.
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hC0DE_F00D;
    @(negedge clk); hi_we = 1'b0; lo_we = 1'b0;
    chk("both_hi", hi, 32'hC0DE_F00D);
    chk("both_lo", lo, 32'hC0DE_F00D);
    repeat (40) @(negedge clk);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
